// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared types and constants for the multiply/divide unit controller.
// Holds the controller FSM state encoding, the MduOpE operation codes and the
// default iteration counts used by mdu_ctrl and mdu_iter_cnt.
package mdu_pkg;

    // Width of the iteration counter (covers cycle counts up to 63).
    localparam int MDU_CNT_W = 6;

    // Default RUN-state iteration counts.
    localparam int MDU_MUL_CYCLES_DEF = 4;
    localparam int MDU_DIV_CYCLES_DEF = 32;

    // MduOpE operation codes.
    localparam logic [1:0] MDU_OP_MUL  = 2'b00;
    localparam logic [1:0] MDU_OP_MULH = 2'b01;
    localparam logic [1:0] MDU_OP_DIV  = 2'b10;
    localparam logic [1:0] MDU_OP_REM  = 2'b11;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // DIV and REM share the iterative divider path; MUL and MULH share the multiplier.
    function automatic logic mdu_op_is_div(input logic [1:0] op);
        return (op == MDU_OP_DIV) || (op == MDU_OP_REM);
    endfunction

    // Index of the final RUN iteration for a given cycle count.
    function automatic logic [MDU_CNT_W-1:0] mdu_last_idx(input int cycles);
        return MDU_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/mdu_iter_cnt.sv
// mdu_iter_cnt -- iteration counter for the MDU controller.
// Clears to zero on clr_i, counts up on en_i, and saturates at last_i so the
// index never runs past the final iteration; tc_o flags the final iteration.
module mdu_iter_cnt
    import mdu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [MDU_CNT_W-1:0] last_i,
    output logic [MDU_CNT_W-1:0] count_o,
    output logic                 tc_o
);

    logic [MDU_CNT_W-1:0] cnt_q;
    logic [MDU_CNT_W-1:0] cnt_d;

    assign tc_o    = (cnt_q == last_i);
    assign count_o = cnt_q;

    // Next count: clear wins, otherwise step until the terminal index, else hold.
    always_comb begin
        // NOTE: the default assignment first guarantees cnt_d is driven on every path, so no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + MDU_CNT_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- sequencing controller for an iterative multiply/divide unit.
// IDLE accepts an E-stage MDU op (operand load), RUN steps the datapath N
// times, DONE presents the result for one cycle. The pipeline front end is
// stalled and M is bubbled while an op is being loaded or iterated.
// Optional build macro: MDU_DIVZERO_FAST_EN -- a DIV/REM with a zero divisor
// skips RUN and completes right after the load cycle.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MduReqE,
    input  logic [1:0]           MduOpE,
    input  logic                 DivZeroE,
    output logic                 MduStall,
    output logic                 MduFlushM,
    output logic                 MduLoad,
    output logic                 MduStep,
    output logic                 MduDone,
    output logic                 MduIsDiv,
    output logic [MDU_CNT_W-1:0] MduCount
);

    localparam logic [MDU_CNT_W-1:0] MUL_LAST = mdu_last_idx(MUL_CYCLES);
    localparam logic [MDU_CNT_W-1:0] DIV_LAST = mdu_last_idx(DIV_CYCLES);

    mdu_state_e           state_q;
    logic                 is_div_q;
    logic                 accept;
    logic                 fast_done;
    logic                 cnt_tc;
    logic [MDU_CNT_W-1:0] cnt_val;
    logic [MDU_CNT_W-1:0] last_idx;

    assign accept   = (state_q == MDU_IDLE) && MduReqE;
    assign last_idx = is_div_q ? DIV_LAST : MUL_LAST;

`ifdef MDU_DIVZERO_FAST_EN
    // A zero divisor has a fixed result, so the iterations are skipped.
    assign fast_done = accept && mdu_op_is_div(MduOpE) && DivZeroE;
`else
    // Zero divisors take the full divide path; the flag is intentionally unused.
    logic unused_div_zero;
    assign unused_div_zero = DivZeroE;
    assign fast_done       = 1'b0;
`endif

    mdu_iter_cnt u_iter_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (accept),
        .en_i    (state_q == MDU_RUN),
        .last_i  (last_idx),
        .count_o (cnt_val),
        .tc_o    (cnt_tc)
    );

    // Controller FSM: state and latched op class, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= MDU_IDLE;
            is_div_q <= 1'b0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (MduReqE) begin
                        is_div_q <= mdu_op_is_div(MduOpE);
                        state_q  <= fast_done ? MDU_DONE : MDU_RUN;
                    end
                end
                MDU_RUN: begin
                    if (cnt_tc) begin
                        state_q <= MDU_DONE;
                    end
                end
                // MduReqE still shows the completing op here, so it must not retrigger.
                MDU_DONE: state_q <= MDU_IDLE;
                default:  state_q <= MDU_IDLE;
            endcase
        end
    end

    // Outputs are state decodes, forced low while reset is held so nothing
    // leaks out during the reset cycle itself.
    assign MduLoad   = reset & accept;
    assign MduStep   = reset & (state_q == MDU_RUN);
    assign MduDone   = reset & (state_q == MDU_DONE);
    assign MduStall  = MduLoad | MduStep;
    assign MduFlushM = MduStall;
    assign MduIsDiv  = reset & is_div_q;
    assign MduCount  = {MDU_CNT_W{reset}} & cnt_val;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4: RUN-state iterations for MUL/MULH (range 1..63).
REQ-002 SHALL have parameter DIV_CYCLES, default 32: RUN-state iterations for DIV/REM (range 1..63).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port MduReqE, input, 1: the E-stage instruction is a multiply/divide op.
REQ-006 SHALL have port MduOpE, input, 2: operation code; 00 MUL, 01 MULH, 10 DIV, 11 REM.
REQ-007 SHALL have port DivZeroE, input, 1: the E-stage divisor operand equals zero.
REQ-008 SHALL have port MduStall, output, 1: stall F, D and E; ORed into the hazard unit's StallF/StallD.
REQ-009 SHALL have port MduFlushM, output, 1: insert a bubble into the M stage.
REQ-010 SHALL have port MduLoad, output, 1: datapath captures operands this cycle.
REQ-011 SHALL have port MduStep, output, 1: datapath performs one iteration this cycle.
REQ-012 SHALL have port MduDone, output, 1: result valid; selected as the E-stage result this cycle.
REQ-013 SHALL have port MduIsDiv, output, 1: latched op class; 1 means DIV/REM.
REQ-014 SHALL have port MduCount, output, 6: current iteration index.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 In IDLE with MduReqE=1: SHALL assert MduLoad=1, latch MduIsDiv=MduOpE[1], clear MduCount to 0, and go to RUN.
REQ-017 In RUN: SHALL assert MduStep=1 and increment MduCount each cycle; at MduCount==N-1 go to DONE (N = DIV_CYCLES if MduIsDiv, else MUL_CYCLES).
REQ-018 MduCount SHALL never exceed N-1 and SHALL hold its value in DONE and IDLE.
REQ-019 In DONE: SHALL assert MduDone=1 and MduStall=0, and go to IDLE unconditionally.
REQ-020 In DONE, MduReqE SHALL be ignored; it still reflects the completing instruction, so no re-trigger occurs.
REQ-021 MduStall SHALL be combinational: (IDLE & MduReqE) | RUN.
REQ-022 MduFlushM SHALL equal MduStall.
REQ-023 Latency: one op SHALL occupy E for N+2 cycles, with MduStall high for N+1 cycles.
REQ-024 Back-to-back ops: a second MduReqE SHALL be accepted in the IDLE cycle immediately after DONE.
REQ-025 MduLoad, MduStep and MduDone SHALL be mutually exclusive.

Reset
REQ-026 When reset=0 at a clock edge: SHALL set state=IDLE, MduCount=0 and MduIsDiv=0.
REQ-027 Reset mid-operation SHALL abort the op; MduDone SHALL NOT be asserted for the aborted op.
REQ-028 While reset is asserted, all outputs SHALL be 0 regardless of MduReqE.

Configuration
REQ-029 With MDU_DIVZERO_FAST_EN defined: IDLE with MduReqE=1, MduOpE[1]=1 and DivZeroE=1 SHALL assert MduLoad and go directly to DONE, giving MduStall for 1 cycle.
REQ-030 Without MDU_DIVZERO_FAST_EN: DivZeroE SHALL be ignored, and division by zero SHALL take the full DIV_CYCLES path.

Structure
REQ-031 Package mdu_pkg SHALL hold the FSM state enum, the MduOpE code constants and the default cycle constants.
REQ-032 The iteration counter SHALL be a sub-module, mdu_iter_cnt, with clear/enable/terminal-count ports.

Verification
REQ-033 Reset, then a MUL request (MduReqE=1, MduOpE=00) -> MduLoad 1 cycle, MduStep 4 cycles, MduDone on cycle 6; MduStall high for cycles 1-5.
REQ-034 DIV request (MduOpE=10, DivZeroE=0) -> 32 MduStep cycles, MduCount runs 0..31, MduDone on cycle 34.
REQ-035 MduReqE held high through DONE, then a new REM request -> no re-trigger in DONE; the new op loads in the next cycle.
REQ-036 Reset=0 at RUN count 10 of a DIV -> IDLE and MduCount=0 next cycle; no MduDone pulse.
REQ-037 DIV with DivZeroE=1 -> with MDU_DIVZERO_FAST_EN: MduDone on cycle 2; without it: MduDone on cycle 34.
REQ-038 Every cycle -> MduFlushM==MduStall, and MduLoad/MduStep/MduDone are one-hot or zero.
